// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter
//   Per-output-port switch stage downstream of the input VC buffers. Picks one
//   requesting VC per cycle (round-robin among packet starts), holds the port
//   for the whole packet once a HEAD wins (wormhole), tracks downstream credits
//   and drives a registered flit stream toward the output link.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-VC front-flit-present flags
//   req_flit    : per-VC front flit, VC i in [i*FLIT_SIZE +: FLIT_SIZE]
//   grant       : combinational one-hot/zero pop strobe back to the VC buffers
//   flit_out    : registered flit toward the link
//   valid_out   : one-cycle pulse per forwarded flit
//   credit_in   : downstream freed one buffer slot
//   credit_cnt  : current downstream credits
//   locked      : port owned by a multi-flit packet
//   owner       : owning VC index (meaningful while locked)
module vc_output_arbiter #(
  parameter int NUM_VC = 4,
  parameter int FLIT_SIZE = 32,
  parameter int HEADER_LEN = 2,
  parameter logic [HEADER_LEN-1:0] HEAD_FLIT = 2'b00,
  parameter logic [HEADER_LEN-1:0] BODY_FLIT = 2'b01,
  parameter logic [HEADER_LEN-1:0] TAIL_FLIT = 2'b10,
  parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
  parameter int CREDIT_MAX = 8,
  localparam int CW = $clog2(CREDIT_MAX + 1),
  localparam int OW = $clog2(NUM_VC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_VC-1:0]           req_valid,
  input  logic [NUM_VC*FLIT_SIZE-1:0] req_flit,
  output logic [NUM_VC-1:0]           grant,
  output logic [FLIT_SIZE-1:0]        flit_out,
  output logic                        valid_out,
  input  logic                        credit_in,
  output logic [CW-1:0]               credit_cnt,
  output logic                        locked,
  output logic [OW-1:0]               owner
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [FLIT_SIZE-1:0]  flit_out_q, flit_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  locked_q, locked_d;

  logic [FLIT_SIZE-1:0]  flit_arr [NUM_VC];
  logic                  sel_valid;
  logic [OW-1:0]         sel_idx;
  logic [HEADER_LEN-1:0] sel_type;
  logic                  has_credit;

  function automatic logic [HEADER_LEN-1:0] flit_type(input logic [FLIT_SIZE-1:0] f);
    return f[FLIT_SIZE-1 -: HEADER_LEN];
  endfunction

  // Only HEAD and SINGLE can open a packet on an idle port.
  function automatic logic is_pkt_start(input logic [HEADER_LEN-1:0] t);
    return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
  endfunction

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    logic [OW-1:0] r;
    if (int'(i) == (NUM_VC - 1)) begin
      r = '0;
    end else begin
      r = i + OW'(1);
    end
    return r;
  endfunction

  // Unpack the flat flit bus into per-VC words.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      flit_arr[i] = req_flit[i*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  // Pick the VC to serve this cycle: round-robin over packet starts when idle,
  // the owner only when locked; nothing at zero credits or during reset.
  always_comb begin : select_p
    int idx;
    idx        = 0;
    sel_valid  = 1'b0;
    sel_idx    = owner_q;
    has_credit = (credit_q != '0);
    if (state_q == ST_IDLE) begin
      if (has_credit) begin
        for (int k = 0; k < NUM_VC; k++) begin
          idx = int'(rr_ptr_q) + k;
          idx = (idx >= NUM_VC) ? (idx - NUM_VC) : idx;
          if (!sel_valid && req_valid[idx] && is_pkt_start(flit_type(flit_arr[idx]))) begin
            sel_valid = 1'b1;
            sel_idx   = OW'(idx);
          end else begin
            sel_valid = sel_valid;
          end
        end
      end else begin
        sel_valid = 1'b0;
      end
    end else begin
      sel_idx   = owner_q;
      sel_valid = req_valid[owner_q] && has_credit;
    end
    if (rst) begin
      sel_valid = 1'b0;
    end else begin
      sel_valid = sel_valid;
    end
    sel_type = flit_type(flit_arr[sel_idx]);
  end

  // One-hot pop strobe to the VC buffers.
  always_comb begin
    if (sel_valid) begin
      grant = NUM_VC'(1) << sel_idx;
    end else begin
      grant = '0;
    end
  end

  // Next-state, credit and output-register computation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    valid_out_d = sel_valid;
    flit_out_d  = sel_valid ? flit_arr[sel_idx] : flit_out_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid && (sel_type == HEAD_FLIT)) begin
          state_d = ST_LOCKED;
          owner_d = sel_idx;
        end else if (sel_valid) begin
          rr_ptr_d = wrap_inc(sel_idx);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        // HEAD/SINGLE from the owner while locked are forwarded as BODY.
        if (sel_valid && (sel_type == TAIL_FLIT)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_inc(owner_q);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({sel_valid, credit_in})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CW'(CREDIT_MAX)) begin
          credit_d = credit_q;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: credit_d = credit_q;
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= CW'(CREDIT_MAX);
      flit_out_q  <= '0;
      valid_out_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      flit_out_q  <= flit_out_d;
      valid_out_q <= valid_out_d;
      locked_q    <= locked_d;
    end
  end

  assign flit_out   = flit_out_q;
  assign valid_out  = valid_out_q;
  assign credit_cnt = credit_q;
  assign locked     = locked_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed testbench for vc_output_arbiter (NUM_VC=4, FLIT_SIZE=32, CREDIT_MAX=8).
// Inputs change 1 time unit after a rising edge; the combinational grant is
// sampled 1 unit later, registered outputs 1 unit after the next rising edge.
module tb_vc_output_arbiter;

  localparam logic [1:0] HEAD   = 2'b00;
  localparam logic [1:0] BODY   = 2'b01;
  localparam logic [1:0] TAIL   = 2'b10;
  localparam logic [1:0] SINGLE = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_flit;
  logic         credit_in;
  logic [3:0]   grant;
  logic [31:0]  flit_out;
  logic         valid_out;
  logic [3:0]   credit_cnt;
  logic         locked;
  logic [1:0]   owner;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vc_output_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_flit  (req_flit),
    .grant     (grant),
    .flit_out  (flit_out),
    .valid_out (valid_out),
    .credit_in (credit_in),
    .credit_cnt(credit_cnt),
    .locked    (locked),
    .owner     (owner)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic set_vc(input int i, input logic [1:0] t, input logic [29:0] p);
    req_flit[i*32 +: 32] = mk(t, p);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational grant settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    credit_in = 1'b0;
    req_flit  = '0;
    req_valid = 4'b0110;
    set_vc(1, SINGLE, 30'h0A1);
    set_vc(2, SINGLE, 30'h0A2);

    // Reset state, grant held low while rst is high despite requests.
    tick();
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_flit", flit_out, 32'h0);
    check("rst_locked", locked, 1'b0);
    check("rst_owner", owner, 2'd0);
    check("rst_credit", credit_cnt, 4'd8);

    // Two SINGLE flits, VC1 then VC2.
    rst = 1'b0;
    settle();
    check("s1_grant_vc1", grant, 4'b0010);
    tick();
    check("s1_valid1", valid_out, 1'b1);
    check("s1_flit1", flit_out, mk(SINGLE, 30'h0A1));
    check("s1_credit7", credit_cnt, 4'd7);
    req_valid = 4'b0100;
    settle();
    check("s1_grant_vc2", grant, 4'b0100);
    tick();
    check("s1_valid2", valid_out, 1'b1);
    check("s1_flit2", flit_out, mk(SINGLE, 30'h0A2));
    check("s1_credit6", credit_cnt, 4'd6);
    req_valid = 4'b0000;
    settle();
    tick();
    check("s1_valid_drop", valid_out, 1'b0);
    check("s1_flit_hold", flit_out, mk(SINGLE, 30'h0A2));
    // rr_ptr is 3: VC3 must beat VC0.
    set_vc(0, SINGLE, 30'h0B0);
    set_vc(3, SINGLE, 30'h0B3);
    req_valid = 4'b1001;
    settle();
    check("s1_rr3", grant, 4'b1000);
    tick();
    check("s1_credit5", credit_cnt, 4'd5);

    // BODY/TAIL at a VC front are never eligible while idle.
    req_valid = 4'b0011;
    set_vc(0, TAIL, 30'h0C0);
    set_vc(1, BODY, 30'h0C1);
    settle();
    check("idle_body_tail", grant, 4'b0000);
    tick();

    // Credits back to the ceiling, then one more is dropped.
    req_valid = 4'b0000;
    credit_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("credit_refill8", credit_cnt, 4'd8);
    tick();
    check("credit_sat8", credit_cnt, 4'd8);
    credit_in = 1'b0;

    // Wormhole: VC0 HEAD/BODY/BODY/TAIL while VC3 holds a HEAD (rr_ptr=0).
    req_valid = 4'b1001;
    set_vc(3, HEAD, 30'h0D3);
    set_vc(0, HEAD, 30'h100);
    settle();
    check("wh_head_grant", grant, 4'b0001);
    tick();
    check("wh_locked", locked, 1'b1);
    check("wh_owner", owner, 2'd0);
    set_vc(0, BODY, 30'h101);
    settle();
    check("wh_body1_grant", grant, 4'b0001);
    tick();
    check("wh_body1_flit", flit_out, mk(BODY, 30'h101));
    set_vc(0, BODY, 30'h102);
    settle();
    check("wh_body2_grant", grant, 4'b0001);
    tick();
    set_vc(0, TAIL, 30'h103);
    settle();
    check("wh_tail_grant", grant, 4'b0001);
    tick();
    check("wh_unlocked", locked, 1'b0);
    check("wh_tail_flit", flit_out, mk(TAIL, 30'h103));
    check("wh_credit4", credit_cnt, 4'd4);
    req_valid = 4'b1000;
    settle();
    check("wh_vc3_next", grant, 4'b1000);
    tick();
    check("wh_vc3_owner", owner, 2'd3);
    set_vc(3, TAIL, 30'h0D4);
    settle();
    check("wh_vc3_tail", grant, 4'b1000);
    tick();
    check("wh_credit2", credit_cnt, 4'd2);

    // Simultaneous transfer and credit_in at credit 5.
    req_valid = 4'b0000;
    credit_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("both_pre5", credit_cnt, 4'd5);
    req_valid = 4'b0010;
    set_vc(1, SINGLE, 30'h0E1);
    settle();
    check("both_grant", grant, 4'b0010);
    tick();
    check("both_credit5", credit_cnt, 4'd5);
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    credit_in = 1'b0;
    check("exh_pre8", credit_cnt, 4'd8);

    // Credit exhaustion with VC2 SINGLE flits.
    req_valid = 4'b0100;
    set_vc(2, SINGLE, 30'h0F2);
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("exh_grant%0d", i), grant, 4'b0100);
      tick();
    end
    check("exh_credit0", credit_cnt, 4'd0);
    settle();
    check("exh_nogrant", grant, 4'b0000);
    tick();
    check("exh_novalid", valid_out, 1'b0);
    credit_in = 1'b1;
    settle();
    check("exh_pulse_nogrant", grant, 4'b0000);
    tick();
    credit_in = 1'b0;
    check("exh_credit1", credit_cnt, 4'd1);
    settle();
    check("exh_one_more", grant, 4'b0100);
    tick();
    check("exh_credit0b", credit_cnt, 4'd0);
    settle();
    check("exh_stop", grant, 4'b0000);
    req_valid = 4'b0000;
    credit_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    credit_in = 1'b0;
    check("exh_restore8", credit_cnt, 4'd8);

    // Bubble while locked to VC1 (rr_ptr=3 so VC1 is found via 3,0,1).
    req_valid = 4'b0010;
    set_vc(1, HEAD, 30'h111);
    settle();
    check("bub_head", grant, 4'b0010);
    tick();
    set_vc(0, HEAD, 30'h110);
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bub_nogrant%0d", i), grant, 4'b0000);
      tick();
      check($sformatf("bub_locked%0d", i), locked, 1'b1);
    end
    check("bub_owner", owner, 2'd1);
    req_valid = 4'b0011;
    set_vc(1, TAIL, 30'h112);
    settle();
    check("bub_tail", grant, 4'b0010);
    tick();
    check("bub_release", locked, 1'b0);
    // rr_ptr=2: VC2 wins over VC0.
    req_valid = 4'b0101;
    set_vc(2, SINGLE, 30'h122);
    settle();
    check("bub_rr2", grant, 4'b0100);
    tick();
    check("bub_credit5", credit_cnt, 4'd5);

    // Protocol error and reset mid-packet (rr_ptr=3, VC0 found via 3,0).
    req_valid = 4'b0001;
    set_vc(0, HEAD, 30'h130);
    settle();
    check("rm_head", grant, 4'b0001);
    tick();
    set_vc(0, SINGLE, 30'h131);
    settle();
    check("rm_err_grant", grant, 4'b0001);
    tick();
    check("rm_err_locked", locked, 1'b1);
    check("rm_credit3", credit_cnt, 4'd3);
    set_vc(0, BODY, 30'h132);
    rst = 1'b1;
    settle();
    check("rm_grant_in_rst", grant, 4'b0000);
    tick();
    check("rm_locked", locked, 1'b0);
    check("rm_credit8", credit_cnt, 4'd8);
    check("rm_valid", valid_out, 1'b0);
    check("rm_grant", grant, 4'b0000);
    rst = 1'b0;
    req_valid = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
